// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the pipelined adder.
package adder_pkg;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;

  function automatic int unsigned stages(input int unsigned width, input int unsigned stage_bits);
    return width / stage_bits;
  endfunction

  function automatic bit params_ok(input int unsigned width, input int unsigned stage_bits);
    return (width >= 1) && (stage_bits >= 1) && ((width % stage_bits) == 0);
  endfunction

  // Stage k keeps its (k+1) sum chunks plus both operands' unconsumed upper bits.
  function automatic int unsigned slice_w(input int unsigned width, input int unsigned stage_bits,
                                          input int unsigned k);
    return 2 * width - (k + 1) * stage_bits;
  endfunction

  function automatic int unsigned slice_off(input int unsigned width, input int unsigned stage_bits,
                                            input int unsigned k);
    int unsigned off;
    off = 0;
    for (int unsigned j = 0; j < k; j++) off += slice_w(width, stage_bits, j);
    return off;
  endfunction

endpackage

// File: rtl/adder_nbit.sv
// Combinational N-bit adder with carry in/out; one chunk of the pipelined adder.
module adder_nbit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int unsigned SUM_W = WIDTH + 1;

  assign {carry_out, sum} = SUM_W'(a) + SUM_W'(b) + SUM_W'(carry_in);

endmodule

// File: rtl/pipelined_adder_nbit.sv
// WIDTH-bit add/subtract split into STAGE_BITS chunks, one chunk per pipeline stage,
// with valid/ready flow control; a stall freezes the whole pipe.
module pipelined_adder_nbit
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned STAGE_BITS = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  localparam int unsigned STAGES = stages(WIDTH, STAGE_BITS);
  localparam int unsigned LAST   = STAGES - 1;
  localparam int unsigned PIPE_W = slice_off(WIDTH, STAGE_BITS, STAGES);
  localparam int unsigned OUT_OFF = slice_off(WIDTH, STAGE_BITS, LAST);

  if (!params_ok(WIDTH, STAGE_BITS)) begin : g_param_check
    $fatal(1, "pipelined_adder_nbit: WIDTH must be >=1 and a multiple of STAGE_BITS");
  end

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [STAGES-1:0] sub_q, sub_d;
  logic [PIPE_W-1:0] pipe_q, pipe_d;
  logic              stall;
  op_e               op_in;
  logic [WIDTH-1:0]  b_eff;

  assign op_in     = op_e'(sub);
  assign b_eff     = (op_in == OP_SUB) ? ~b : b;
  assign stall     = valid_q[LAST] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = valid_q[LAST];
  assign sum       = pipe_q[OUT_OFF +: WIDTH];
  // Subtract reports borrow, i.e. the inverted final carry.
  assign overflow  = carry_q[LAST] ^ sub_q[LAST];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned OFF = slice_off(WIDTH, STAGE_BITS, k);
    localparam int unsigned SW  = slice_w(WIDTH, STAGE_BITS, k);

    logic [STAGE_BITS-1:0] op_a, op_b, chunk_sum;
    logic                  chunk_cin, chunk_cout;

    adder_nbit #(.WIDTH(STAGE_BITS)) u_adder (
      .a        (op_a),
      .b        (op_b),
      .carry_in (chunk_cin),
      .sum      (chunk_sum),
      .carry_out(chunk_cout)
    );

    assign carry_d[k] = chunk_cout;

    if (k == 0) begin : g_first
      assign op_a      = a[STAGE_BITS-1:0];
      assign op_b      = b_eff[STAGE_BITS-1:0];
      assign chunk_cin = (op_in == OP_SUB) ? 1'b1 : carry_in;
      assign valid_d[0] = in_valid;
      assign sub_d[0]   = (op_in == OP_SUB);
      if (STAGES == 1) begin : g_only
        assign pipe_d[OFF +: SW] = chunk_sum;
      end else begin : g_more
        assign pipe_d[OFF +: SW] = {b_eff[WIDTH-1:STAGE_BITS], a[WIDTH-1:STAGE_BITS], chunk_sum};
      end
    end else begin : g_next
      localparam int unsigned POFF = slice_off(WIDTH, STAGE_BITS, k - 1);
      localparam int unsigned PSW  = slice_w(WIDTH, STAGE_BITS, k - 1);
      localparam int unsigned LO   = k * STAGE_BITS;
      localparam int unsigned REM  = WIDTH - LO;

      logic [REM-1:0] a_rem, b_rem;
      logic [LO-1:0]  sum_lo;

      // Previous slice layout: {b_rem, a_rem, sum_lo}; low chunk of each operand is ours.
      assign {b_rem, a_rem, sum_lo} = pipe_q[POFF +: PSW];
      assign op_a       = a_rem[STAGE_BITS-1:0];
      assign op_b       = b_rem[STAGE_BITS-1:0];
      assign chunk_cin  = carry_q[k-1];
      assign valid_d[k] = valid_q[k-1];
      assign sub_d[k]   = sub_q[k-1];
      if (k == STAGES - 1) begin : g_last
        assign pipe_d[OFF +: SW] = {chunk_sum, sum_lo};
      end else begin : g_mid
        assign pipe_d[OFF +: SW] = {b_rem[REM-1:STAGE_BITS], a_rem[REM-1:STAGE_BITS],
                                    chunk_sum, sum_lo};
      end
    end
  end

  // Pipeline registers advance together or not at all.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_q <= '0;
      carry_q <= '0;
      sub_q   <= '0;
      pipe_q  <= '0;
    end else if (!stall) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      pipe_q  <= pipe_d;
    end
  end

endmodule
